text_cell_sched: RTL and testbench
==================================

Name: text_cell_sched

Overview:
- Scheduler and arbiter for the 16x12 character-cell buffer that feeds the 5x7 font overlay on the NTSC square-pixel video path.
- Arbitrates cell writes from several requesters (timestamp, dice, user data) into a shadow buffer.
- Copies the shadow buffer to the live buffer once per frame, at a programmable blanking line, so the overlay never tears.
- The live buffer output drives the font block's cell-data bus directly.

Parameters:
- C_REQ_N, 3, number of write requesters.
- C_COLS, 16, cells per row.
- C_ROWS, 12, cell rows.
- C_CODE_W, 5, cell code width: {valid, nibble}; code 0 = blank.
- C_ADR_W, 8, cell address width; address = row*C_COLS+col; must satisfy 2**C_ADR_W >= C_COLS*C_ROWS.
- C_COMMIT_LINE, 9'd4, VCTR value at which a commit is scheduled (inside vertical blanking).

Ports:
- CK_i  in  1  system clock (n x 12.27272 MHz).
- XSRST_i  in  1  reset, synchronous, active-low.
- PX_CK_EE_i  in  1  pixel clock enable from the NTSC timing generator.
- VCTRs_i  in  9  line counter from the NTSC timing generator.
- REQs_i  in  C_REQ_N  write request per requester; level, held until granted.
- REQ_ADRss_i  in  C_REQ_N*C_ADR_W  cell address per requester; requester k occupies slice k.
- REQ_CODEss_i  in  C_REQ_N*C_CODE_W  cell code per requester; requester k occupies slice k.
- CLR_i  in  1  request to blank the whole shadow buffer.
- GNTs_o  out  C_REQ_N  one-hot, one-cycle grant; the write completes in that same cycle.
- OOR_o  out  1  one-cycle pulse: the granted address was >= C_COLS*C_ROWS, so the write was dropped.
- BUSY_o  out  1  high while in S_CLEAR or S_COMMIT.
- COMMIT_o  out  1  one-cycle pulse: the live buffer was updated this cycle.
- DISP_DATss_o  out  C_COLS*C_ROWS*C_CODE_W  live buffer; cell a occupies slice a.

Behaviour:
- Reset (XSRST_i=0 at a CK_i rising edge):
  - Shadow and live buffers all 0; dirty=0; round-robin pointer=0.
  - State S_IDLE; all outputs 0.
  - Reset mid-CLEAR or mid-COMMIT aborts the operation immediately.
- Commit trigger:
  - Condition: PX_CK_EE_i=1 and VCTRs_i==C_COMMIT_LINE and the previously sampled enabled VCTR != C_COMMIT_LINE.
  - Fires once per frame; the line-match flag is tracked on PX_CK_EE_i only.
- S_IDLE:
  - Arbiter grants at most one requester per CK_i cycle.
  - Round-robin: search starts at pointer; after a grant to k, pointer = (k+1) mod C_REQ_N.
  - Grant writes REQ_CODE[k] to shadow[REQ_ADR[k]] in the same cycle and sets dirty=1.
  - Out-of-range address: grant is still issued, shadow is unchanged, dirty is unchanged, OOR_o=1.
  - Priority order when several events coincide: reset > commit trigger > CLR_i > grant.
  - Trigger with dirty=1: latch trigger and go to S_COMMIT. A grant in the same cycle is still performed and is included in the commit.
  - Trigger with dirty=0: ignored; COMMIT_o stays 0.
  - CLR_i=1 without a trigger: go to S_CLEAR with ctr=0; no grant that cycle.
- S_CLEAR:
  - Writes 0 to shadow[ctr], one cell per cycle, ctr = 0..C_COLS*C_ROWS-1; no grants.
  - After the last cell: dirty=1, return to S_IDLE.
  - A trigger during S_CLEAR is dropped; the commit happens next frame.
  - CLR_i during S_CLEAR is ignored.
- S_COMMIT (one cycle):
  - live <= shadow; dirty=0; COMMIT_o=1; no grants.
  - Next state S_IDLE.
- Latency:
  - Write to shadow: 0 cycles after grant.
  - Shadow to live: 1 cycle after trigger detection.
  - DISP_DATss_o changes only at the edge that ends S_COMMIT.
- A requester holding REQ through a grant is granted again at its next round-robin turn; requesters must drop REQ the cycle after GNT.

Optional Feature:
- Macro TEXT_CELL_SCHED_FIXED_PRI_EN.
- Defined: fixed priority, lowest index wins; the round-robin pointer is removed.
- Undefined: round-robin as above.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package/include text_cell_pkg.vh holds:
  - cell-count and address-width constants;
  - C_CODE_W;
  - state encodings S_IDLE=2'd0, S_CLEAR=2'd1, S_COMMIT=2'd2;
  - BLANK code 0.
- One sub-module: rr_arbiter (C_REQ_N requests, enable, one-hot grant, pointer update).
  - It also implements the fixed-priority variant under the macro.

Test Plan:
- Reset: hold XSRST_i=0 for 3 cycles with REQs=3'b111 -> GNTs_o=0, DISP_DATss_o=0, COMMIT_o=0.
- Round-robin: REQs=3'b111 held, addresses 1, 2, 3 -> GNTs_o sequence 001, 010, 100, 001.
  - With TEXT_CELL_SCHED_FIXED_PRI_EN defined -> 001, 001, 001.
- Deferred update: requester 0 writes code 5'h13 to addr 17 at VCTR=100.
  - DISP_DATss_o slice 17 stays 0 until VCTR reaches 4 -> then 5'h13 with one COMMIT_o pulse.
  - Next frame with no writes -> no COMMIT_o.
- Out of range: write to addr 192 -> GNT and OOR_o pulse; shadow unchanged; no commit that frame.
- Clear: load cells, then pulse CLR_i -> BUSY_o high exactly 192 cycles, no grants during it.
  - After the next commit, all cells read 0.
  - A trigger during the clear is dropped and the commit happens the following frame.
- Collision: grant to addr 9 in the same cycle as the trigger -> the value appears in live in that frame's commit.

Source files
------------

// File: rtl/text_cell_sched_pkg.sv
// Shared constants, cell geometry and FSM encoding for the text-cell scheduler.
// Build option: TEXT_CELL_SCHED_FIXED_PRI_EN selects fixed-priority arbitration.
package text_cell_pkg;

    localparam int C_REQ_N  = 3;
    localparam int C_COLS   = 16;
    localparam int C_ROWS   = 12;
    localparam int C_CELLS  = C_COLS * C_ROWS;
    localparam int C_CODE_W = 5;
    localparam int C_ADR_W  = 8;
    localparam int C_PTR_W  = (C_REQ_N > 1) ? $clog2(C_REQ_N) : 1;

    localparam logic [8:0]          C_COMMIT_LINE = 9'd4;
    localparam logic [C_CODE_W-1:0] C_BLANK       = '0;
    localparam logic [C_ADR_W-1:0]  C_LAST_CELL   = C_ADR_W'(C_CELLS - 1);
    localparam logic [C_ADR_W-1:0]  C_CELLS_ADR   = C_ADR_W'(C_CELLS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CLEAR  = 2'd1,
        S_COMMIT = 2'd2
    } state_e;

endpackage

// File: rtl/text_cell_sched_rr_arbiter.sv
// One-hot single-grant arbiter; round-robin by default, fixed priority
// (lowest index wins, no pointer) when TEXT_CELL_SCHED_FIXED_PRI_EN is defined.
module rr_arbiter
    import text_cell_pkg::*;
(
    input  logic               CK_i,
    input  logic               XSRST_i,
    input  logic               EN_i,
    input  logic [C_REQ_N-1:0] REQs_i,
    output logic [C_REQ_N-1:0] GNTs_o,
    output logic [C_PTR_W-1:0] GNT_IDX_o,
    output logic               GNT_VLD_o
);

`ifdef TEXT_CELL_SCHED_FIXED_PRI_EN
    logic unused_clk_rst;
    assign unused_clk_rst = CK_i ^ XSRST_i;

    always_comb begin
        GNTs_o    = '0;
        GNT_IDX_o = '0;
        GNT_VLD_o = 1'b0;
        for (int i = C_REQ_N - 1; i >= 0; i--) begin
            if (EN_i && REQs_i[i]) begin
                GNTs_o    = '0;
                GNTs_o[i] = 1'b1;
                GNT_IDX_o = C_PTR_W'(i);
                GNT_VLD_o = 1'b1;
            end
        end
    end
`else
    logic [C_PTR_W-1:0] ptr_q, ptr_d;

    // Search starts at the pointer and wraps; the first hit wins.
    always_comb begin : rr_search
        int  idx;
        logic found;
        found     = 1'b0;
        idx       = 0;
        GNTs_o    = '0;
        GNT_IDX_o = '0;
        ptr_d     = ptr_q;
        for (int i = 0; i < C_REQ_N; i++) begin
            idx = (int'(ptr_q) + i) % C_REQ_N;
            if (EN_i && !found && REQs_i[idx]) begin
                found       = 1'b1;
                GNTs_o[idx] = 1'b1;
                GNT_IDX_o   = C_PTR_W'(idx);
                ptr_d       = C_PTR_W'((idx + 1) % C_REQ_N);
            end
        end
        GNT_VLD_o = found;
    end

    always_ff @(posedge CK_i) begin
        if (!XSRST_i) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end
`endif

endmodule

// File: rtl/text_cell_sched.sv
// Cell-write arbiter with a shadow buffer copied to the live buffer once per frame.
// Build option: TEXT_CELL_SCHED_FIXED_PRI_EN (fixed-priority arbitration).
module text_cell_sched
    import text_cell_pkg::*;
(
    input  logic                          CK_i,
    input  logic                          XSRST_i,
    input  logic                          PX_CK_EE_i,
    input  logic [8:0]                    VCTRs_i,
    input  logic [C_REQ_N-1:0]            REQs_i,
    input  logic [C_REQ_N*C_ADR_W-1:0]    REQ_ADRss_i,
    input  logic [C_REQ_N*C_CODE_W-1:0]   REQ_CODEss_i,
    input  logic                          CLR_i,
    output logic [C_REQ_N-1:0]            GNTs_o,
    output logic                          OOR_o,
    output logic                          BUSY_o,
    output logic                          COMMIT_o,
    output logic [C_CELLS*C_CODE_W-1:0]   DISP_DATss_o
);

    state_e                           state_q, state_d;
    logic                             line_match_q;
    logic                             dirty_q;
    logic [C_ADR_W-1:0]               ctr_q;
    logic [C_CELLS-1:0][C_CODE_W-1:0] shadow_q;
    logic [C_CELLS-1:0][C_CODE_W-1:0] live_q;

    logic                trig, commit_go, clr_go, arb_en;
    logic [C_REQ_N-1:0]  gnt;
    logic [C_PTR_W-1:0]  gnt_idx;
    logic                gnt_vld;
    logic [C_ADR_W-1:0]  gnt_adr;
    logic [C_CODE_W-1:0] gnt_code;
    logic                adr_ok;

    // Rising edge of the line match, seen only on enabled pixel clocks.
    assign trig      = PX_CK_EE_i && (VCTRs_i == C_COMMIT_LINE) && !line_match_q;
    assign commit_go = (state_q == S_IDLE) && trig && dirty_q;
    assign clr_go    = (state_q == S_IDLE) && !commit_go && CLR_i;
    assign arb_en    = XSRST_i && (state_q == S_IDLE) && !clr_go;

    rr_arbiter u_arb (
        .CK_i      (CK_i),
        .XSRST_i   (XSRST_i),
        .EN_i      (arb_en),
        .REQs_i    (REQs_i),
        .GNTs_o    (gnt),
        .GNT_IDX_o (gnt_idx),
        .GNT_VLD_o (gnt_vld)
    );

    assign gnt_adr  = REQ_ADRss_i[int'(gnt_idx)*C_ADR_W +: C_ADR_W];
    assign gnt_code = REQ_CODEss_i[int'(gnt_idx)*C_CODE_W +: C_CODE_W];
    assign adr_ok   = gnt_adr < C_CELLS_ADR;

    always_ff @(posedge CK_i) begin
        if (!XSRST_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (commit_go)            state_d = S_COMMIT;
                      else if (clr_go)          state_d = S_CLEAR;
            S_CLEAR:  if (ctr_q == C_LAST_CELL) state_d = S_IDLE;
            S_COMMIT:                           state_d = S_IDLE;
            default:                            state_d = S_IDLE;
        endcase
    end

    always_comb begin
        GNTs_o   = gnt;
        OOR_o    = gnt_vld && !adr_ok;
        BUSY_o   = (state_q == S_CLEAR) || (state_q == S_COMMIT);
        COMMIT_o = (state_q == S_COMMIT);
    end

    // A grant in the commit-trigger cycle lands in shadow before the copy.
    always_ff @(posedge CK_i) begin
        if (!XSRST_i) begin
            shadow_q     <= '0;
            live_q       <= '0;
            dirty_q      <= 1'b0;
            ctr_q        <= '0;
            line_match_q <= 1'b0;
        end else begin
            if (PX_CK_EE_i) line_match_q <= (VCTRs_i == C_COMMIT_LINE);
            case (state_q)
                S_IDLE: begin
                    if (gnt_vld && adr_ok) begin
                        shadow_q[gnt_adr] <= gnt_code;
                        dirty_q           <= 1'b1;
                    end
                    if (clr_go) ctr_q <= '0;
                end
                S_CLEAR: begin
                    shadow_q[ctr_q] <= C_BLANK;
                    ctr_q           <= ctr_q + C_ADR_W'(1);
                    if (ctr_q == C_LAST_CELL) dirty_q <= 1'b1;
                end
                S_COMMIT: begin
                    live_q  <= shadow_q;
                    dirty_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign DISP_DATss_o = live_q;

endmodule

// File: tb/tb_text_cell_sched.sv
// Randomized bench for text_cell_sched against a frame-level model of the
// shadow/live buffers and the arbitration order.
module tb_text_cell_sched;
    import text_cell_pkg::*;

    logic                        clk = 1'b0;
    logic                        XSRST_i;
    logic                        PX_CK_EE_i;
    logic [8:0]                  VCTRs_i;
    logic [C_REQ_N-1:0]          REQs_i;
    logic [C_REQ_N*C_ADR_W-1:0]  REQ_ADRss_i;
    logic [C_REQ_N*C_CODE_W-1:0] REQ_CODEss_i;
    logic                        CLR_i;
    logic [C_REQ_N-1:0]          GNTs_o;
    logic                        OOR_o, BUSY_o, COMMIT_o;
    logic [C_CELLS*C_CODE_W-1:0] DISP_DATss_o;

    always #5 clk = ~clk;

    text_cell_sched dut (
        .CK_i(clk), .XSRST_i(XSRST_i), .PX_CK_EE_i(PX_CK_EE_i), .VCTRs_i(VCTRs_i),
        .REQs_i(REQs_i), .REQ_ADRss_i(REQ_ADRss_i), .REQ_CODEss_i(REQ_CODEss_i),
        .CLR_i(CLR_i), .GNTs_o(GNTs_o), .OOR_o(OOR_o), .BUSY_o(BUSY_o),
        .COMMIT_o(COMMIT_o), .DISP_DATss_o(DISP_DATss_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [C_CODE_W-1:0] shadow_m [C_CELLS];
    logic [C_CODE_W-1:0] live_m   [C_CELLS];
    bit                  dirty_m;
    int                  ptr_m;
    bit                  prev_match_m;
    logic [C_REQ_N-1:0]  exp_q [$];

    function automatic logic [C_CELLS*C_CODE_W-1:0] model_disp();
        logic [C_CELLS*C_CODE_W-1:0] v;
        for (int a = 0; a < C_CELLS; a++) v[a*C_CODE_W +: C_CODE_W] = live_m[a];
        return v;
    endfunction

    function automatic int first_diff();
        for (int a = 0; a < C_CELLS; a++)
            if (DISP_DATss_o[a*C_CODE_W +: C_CODE_W] !== live_m[a]) return a;
        return 0;
    endfunction

    // One idle cycle of requests; the expected winner comes from a rotating search.
    task automatic drive_req(input logic [C_REQ_N-1:0] r,
                             input logic [C_REQ_N*C_ADR_W-1:0] adrs,
                             input logic [C_REQ_N*C_CODE_W-1:0] codes);
        int                 win;
        int                 k;
        logic [C_REQ_N-1:0] exp_g;
        logic [C_ADR_W-1:0] a;
        bit                 exp_oor;
        REQs_i = r; REQ_ADRss_i = adrs; REQ_CODEss_i = codes;
        win = -1; exp_g = '0; exp_oor = 1'b0; a = '0;
        for (int i = 0; i < C_REQ_N; i++) begin
            k = (ptr_m + i) % C_REQ_N;
            if (win < 0 && r[k]) win = k;
        end
        if (win >= 0) begin
            exp_g[win] = 1'b1;
            a = adrs[win*C_ADR_W +: C_ADR_W];
            exp_oor = (int'(a) >= C_CELLS);
        end
        @(negedge clk);
        n_checks++;
        if (GNTs_o !== exp_g) begin
            n_errors++;
            $display("FAIL grant: req=%b got %b expected %b", r, GNTs_o, exp_g);
        end
        n_checks++;
        if (OOR_o !== exp_oor) begin
            n_errors++;
            $display("FAIL oor: adr=%0d got %b expected %b", a, OOR_o, exp_oor);
        end
        if (win >= 0) begin
            if (!exp_oor) begin
                shadow_m[a] = codes[win*C_CODE_W +: C_CODE_W];
                dirty_m = 1'b1;
            end
`ifndef TEXT_CELL_SCHED_FIXED_PRI_EN
            ptr_m = (win + 1) % C_REQ_N;
`endif
        end
        @(posedge clk); #1;
        REQs_i = '0;
    endtask

    // Walks a frame's worth of lines through the commit line, one enable per line.
    task automatic run_frame(output int n_commit);
        int  lines [9];
        bit  trig, exp_c;
        int  d;
        lines = '{5, 100, 262, 0, 1, 2, 3, 4, 5};
        n_commit = 0;
        foreach (lines[i]) begin
            VCTRs_i = 9'(lines[i]); PX_CK_EE_i = 1'b1;
            trig = (lines[i] == 4) && !prev_match_m;
            prev_match_m = (lines[i] == 4);
            @(negedge clk);
            n_checks++;
            if (COMMIT_o !== 1'b0) begin
                n_errors++;
                $display("FAIL commit_early: line %0d got %b expected 0", lines[i], COMMIT_o);
            end
            @(posedge clk); #1;
            PX_CK_EE_i = 1'b0;
            exp_c = trig && dirty_m;
            @(negedge clk);
            n_checks++;
            if (COMMIT_o !== exp_c || BUSY_o !== exp_c) begin
                n_errors++;
                $display("FAIL commit_pulse: line %0d got commit=%b busy=%b expected %b",
                         lines[i], COMMIT_o, BUSY_o, exp_c);
            end
            n_checks++;
            if (DISP_DATss_o !== model_disp()) begin
                d = first_diff();
                n_errors++;
                $display("FAIL disp_hold: line %0d cell %0d got %h expected %h",
                         lines[i], d, DISP_DATss_o[d*C_CODE_W +: C_CODE_W], live_m[d]);
            end
            if (COMMIT_o === 1'b1) n_commit++;
            if (exp_c) begin
                live_m = shadow_m;
                dirty_m = 1'b0;
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_checks++;
        if (DISP_DATss_o !== model_disp()) begin
            d = first_diff();
            n_errors++;
            $display("FAIL disp_frame: cell %0d got %h expected %h",
                     d, DISP_DATss_o[d*C_CODE_W +: C_CODE_W], live_m[d]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        XSRST_i = 1'b0; REQs_i = '1; CLR_i = 1'b0; PX_CK_EE_i = 1'b0; VCTRs_i = 9'd0;
        REQ_ADRss_i = {8'd3, 8'd2, 8'd1}; REQ_CODEss_i = '1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (GNTs_o !== '0 || COMMIT_o !== 1'b0 || BUSY_o !== 1'b0 || OOR_o !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_outs: got gnt=%b commit=%b busy=%b oor=%b expected 0",
                         GNTs_o, COMMIT_o, BUSY_o, OOR_o);
            end
            n_checks++;
            if (DISP_DATss_o !== '0) begin
                n_errors++;
                $display("FAIL reset_disp: got nonzero expected 0");
            end
        end
        @(posedge clk); #1;
        XSRST_i = 1'b1; REQs_i = '0;
        foreach (shadow_m[a]) begin shadow_m[a] = '0; live_m[a] = '0; end
        dirty_m = 1'b0; ptr_m = 0; prev_match_m = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [C_REQ_N-1:0] exp_g;
        logic [C_REQ_N*C_CODE_W-1:0] codes;
`ifdef TEXT_CELL_SCHED_FIXED_PRI_EN
        exp_q = '{3'b001, 3'b001, 3'b001, 3'b001};
`else
        exp_q = '{3'b001, 3'b010, 3'b100, 3'b001};
`endif
        codes = C_REQ_N*C_CODE_W'($urandom);
        REQs_i = 3'b111; REQ_ADRss_i = {8'd3, 8'd2, 8'd1}; REQ_CODEss_i = codes;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            exp_g = exp_q.pop_front();
            n_checks++;
            if (GNTs_o !== exp_g) begin
                n_errors++;
                $display("FAIL rr_seq: step %0d got %b expected %b", c, GNTs_o, exp_g);
            end
            for (int k = 0; k < C_REQ_N; k++)
                if (exp_g[k]) begin
                    shadow_m[k + 1] = codes[k*C_CODE_W +: C_CODE_W];
                    dirty_m = 1'b1;
`ifndef TEXT_CELL_SCHED_FIXED_PRI_EN
                    ptr_m = (k + 1) % C_REQ_N;
`endif
                end
            @(posedge clk); #1;
        end
        REQs_i = '0;
    endtask

    task automatic test_deferred();
        int nc;
        VCTRs_i = 9'd100; PX_CK_EE_i = 1'b1; prev_match_m = 1'b0;
        drive_req(3'b001, {8'd0, 8'd0, 8'd17}, {5'd0, 5'd0, 5'h13});
        PX_CK_EE_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (DISP_DATss_o[17*C_CODE_W +: C_CODE_W] !== 5'h00) begin
            n_errors++;
            $display("FAIL deferred_early: cell 17 got %h expected 00",
                     DISP_DATss_o[17*C_CODE_W +: C_CODE_W]);
        end
        @(posedge clk); #1;
        run_frame(nc);
        n_checks++;
        if (nc != 1 || DISP_DATss_o[17*C_CODE_W +: C_CODE_W] !== 5'h13) begin
            n_errors++;
            $display("FAIL deferred_commit: commits %0d cell17 %h expected 1 and 13",
                     nc, DISP_DATss_o[17*C_CODE_W +: C_CODE_W]);
        end
        run_frame(nc);
        n_checks++;
        if (nc != 0) begin
            n_errors++;
            $display("FAIL idle_frame: commits %0d expected 0", nc);
        end
    endtask

    task automatic test_oor();
        int                          nc;
        int                          k;
        logic [C_REQ_N*C_ADR_W-1:0]  adrs;
        logic [C_REQ_N-1:0]          r;
        k = $urandom_range(0, C_REQ_N - 1);
        adrs = '0; r = '0; r[k] = 1'b1;
        adrs[k*C_ADR_W +: C_ADR_W] = (k == 0) ? 8'd192 : C_ADR_W'($urandom_range(192, 255));
        drive_req(r, adrs, C_REQ_N*C_CODE_W'($urandom));
        run_frame(nc);
        n_checks++;
        if (nc != 0) begin
            n_errors++;
            $display("FAIL oor_commit: commits %0d expected 0", nc);
        end
    endtask

    task automatic test_random();
        int nc;
        logic [C_REQ_N*C_ADR_W-1:0] adrs;
        for (int c = 0; c < 30; c++) begin
            for (int k = 0; k < C_REQ_N; k++)
                adrs[k*C_ADR_W +: C_ADR_W] = C_ADR_W'($urandom_range(0, 199));
            drive_req(C_REQ_N'($urandom), adrs, C_REQ_N*C_CODE_W'($urandom));
        end
        run_frame(nc);
    endtask

    task automatic test_clear();
        int n;
        int nc;
        logic [C_REQ_N*C_ADR_W-1:0] adrs;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < C_REQ_N; k++)
                adrs[k*C_ADR_W +: C_ADR_W] = C_ADR_W'($urandom_range(0, C_CELLS - 1));
            drive_req(3'b111, adrs, C_REQ_N*C_CODE_W'($urandom) | 15'h4210);
        end
        CLR_i = 1'b1; REQs_i = 3'b111;
        @(negedge clk);
        n_checks++;
        if (GNTs_o !== '0) begin
            n_errors++;
            $display("FAIL clr_start_grant: got %b expected 000", GNTs_o);
        end
        @(posedge clk); #1;
        CLR_i = 1'b0;
        n = 0;
        while (n < 400) begin
            @(negedge clk);
            if (!BUSY_o) break;
            n++;
            n_checks++;
            if (GNTs_o !== '0 || COMMIT_o !== 1'b0) begin
                n_errors++;
                $display("FAIL clr_busy: cycle %0d got gnt=%b commit=%b expected 0", n, GNTs_o, COMMIT_o);
            end
            @(posedge clk); #1;
            if (n == 50) begin VCTRs_i = 9'd4; PX_CK_EE_i = 1'b1; prev_match_m = 1'b1; end
            if (n == 51) begin PX_CK_EE_i = 1'b0; VCTRs_i = 9'd5; end
            if (n == C_CELLS) REQs_i = '0;
        end
        n_checks++;
        if (n != C_CELLS) begin
            n_errors++;
            $display("FAIL clr_len: busy cycles %0d expected %0d", n, C_CELLS);
        end
        REQs_i = '0;
        @(posedge clk); #1;
        foreach (shadow_m[a]) shadow_m[a] = '0;
        dirty_m = 1'b1;
        run_frame(nc);
        n_checks++;
        if (nc != 1 || DISP_DATss_o !== '0) begin
            n_errors++;
            $display("FAIL clr_commit: commits %0d expected 1, live nonzero=%b", nc, |DISP_DATss_o);
        end
    endtask

    task automatic test_collision();
        int                  k;
        logic [C_CODE_W-1:0] code;
        logic [C_REQ_N-1:0]  r;
        logic [C_REQ_N*C_ADR_W-1:0] adrs;
        drive_req(3'b010, {8'd0, 8'd30, 8'd0}, {5'd0, 5'h1a, 5'd0});
        VCTRs_i = 9'd3; PX_CK_EE_i = 1'b1; prev_match_m = 1'b0;
        @(posedge clk); #1;
        k = $urandom_range(0, C_REQ_N - 1);
        code = C_CODE_W'($urandom_range(16, 31));
        r = '0; r[k] = 1'b1; adrs = '0; adrs[k*C_ADR_W +: C_ADR_W] = 8'd9;
        VCTRs_i = 9'd4; prev_match_m = 1'b1;
        drive_req(r, adrs, {C_REQ_N{code}});
        PX_CK_EE_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (COMMIT_o !== 1'b1) begin
            n_errors++;
            $display("FAIL collision_commit: got %b expected 1", COMMIT_o);
        end
        live_m = shadow_m; dirty_m = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (DISP_DATss_o[9*C_CODE_W +: C_CODE_W] !== code) begin
            n_errors++;
            $display("FAIL collision_cell: cell 9 got %h expected %h",
                     DISP_DATss_o[9*C_CODE_W +: C_CODE_W], code);
        end
        n_checks++;
        if (DISP_DATss_o !== model_disp()) begin
            n_errors++;
            $display("FAIL collision_disp: cell %0d differs", first_diff());
        end
        @(posedge clk); #1;
        VCTRs_i = 9'd5;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_deferred();
        test_oor();
        test_random();
        test_clear();
        test_collision();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
